// File: rtl/snow64_bfloat16_vector_cmp_sequencer_if.sv
`default_nettype none
//==============================================================================
// Module   : snow64_bfloat16_vector_cmp_sequencer_if
// Brief    : Command/result bundle between vector issue and the cmp sequencer.
// Revision : 1.0 - initial release
//==============================================================================
interface snow64_bfloat16_vector_cmp_sequencer_if #(
    parameter int NUM_LANES = 16
);
    logic                   in_start;
    logic [1:0]             in_op;
    logic [16*NUM_LANES-1:0] in_a;
    logic [16*NUM_LANES-1:0] in_b;
    logic [NUM_LANES-1:0]   in_lane_mask;
    logic                   out_can_accept_cmd;
    logic                   out_data_valid;
    logic [NUM_LANES-1:0]   out_mask;
    logic                   out_any;
    logic                   out_all;

    modport master (
        output in_start, in_op, in_a, in_b, in_lane_mask,
        input  out_can_accept_cmd, out_data_valid, out_mask, out_any, out_all
    );

    modport slave (
        input  in_start, in_op, in_a, in_b, in_lane_mask,
        output out_can_accept_cmd, out_data_valid, out_mask, out_any, out_all
    );
endinterface
`default_nettype wire

// File: rtl/snow64_bfloat16_vector_cmp_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : snow64_bfloat16_vector_cmp_sequencer
// Brief    : Walks one shared BFloat16 slt comparator across all vector lanes
//            to build a per-lane predicate mask (slt/sgt/sle/sge).
// Revision : 1.0 - initial release
//==============================================================================
module snow64_bfloat16_vector_cmp_sequencer #(
    parameter int NUM_LANES = 16
) (
    input wire clk,
    input wire rst,
    snow64_bfloat16_vector_cmp_sequencer_if.slave bus
);
    localparam int                  c_LANE_W = $clog2(NUM_LANES);
    localparam logic [c_LANE_W-1:0] c_LAST   = c_LANE_W'(NUM_LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    logic [c_LANE_W-1:0]     r_cnt;
    logic [1:0]              r_op;
    logic [16*NUM_LANES-1:0] r_a;
    logic [16*NUM_LANES-1:0] r_b;
    logic [NUM_LANES-1:0]    r_lane_mask;
    logic [NUM_LANES-1:0]    r_work;

    logic                    r_out_can_accept;
    logic                    r_out_valid;
    logic [NUM_LANES-1:0]    r_out_mask;
    logic                    r_out_any;
    logic                    r_out_all;

    logic [15:0]             w_a_lane [NUM_LANES];
    logic [15:0]             w_b_lane [NUM_LANES];
    logic [15:0]             w_cmp_x;
    logic [15:0]             w_cmp_y;
    logic                    w_swap;
    logic                    w_invert;
    logic                    w_slt;
    logic                    w_bit;
    logic                    w_last;
    logic [NUM_LANES-1:0]    w_work_next;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane_split
            assign w_a_lane[gi] = r_a[16*gi +: 16];
            assign w_b_lane[gi] = r_b[16*gi +: 16];
        end
    endgenerate

    // Sign-magnitude ordering; both zeros (any sign) are equal, NaN not special.
    function automatic logic bf16_slt(input logic [15:0] x, input logic [15:0] y);
        logic res;
        if ((x[14:0] == 15'd0) && (y[14:0] == 15'd0)) begin
            res = 1'b0;
        end else if (x[15] != y[15]) begin
            res = x[15];
        end else if (x[15]) begin
            res = (x[14:0] > y[14:0]);
        end else begin
            res = (x[14:0] < y[14:0]);
        end
        return res;
    endfunction

    always_comb begin
        w_swap   = (r_op == 2'd1) || (r_op == 2'd2);
        w_invert = r_op[1];
        w_cmp_x  = w_swap ? w_b_lane[r_cnt] : w_a_lane[r_cnt];
        w_cmp_y  = w_swap ? w_a_lane[r_cnt] : w_b_lane[r_cnt];
        w_slt    = bf16_slt(w_cmp_x, w_cmp_y);
        w_bit    = (w_slt ^ w_invert) & r_lane_mask[r_cnt];
        w_last   = (r_cnt == c_LAST);
        w_work_next        = r_work;
        w_work_next[r_cnt] = w_bit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_cnt            <= '0;
            r_op             <= '0;
            r_a              <= '0;
            r_b              <= '0;
            r_lane_mask      <= '0;
            r_work           <= '0;
            r_out_can_accept <= 1'b1;
            r_out_valid      <= 1'b0;
            r_out_mask       <= '0;
            r_out_any        <= 1'b0;
            r_out_all        <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.in_start) begin
                        r_op             <= bus.in_op;
                        r_a              <= bus.in_a;
                        r_b              <= bus.in_b;
                        r_lane_mask      <= bus.in_lane_mask;
                        r_work           <= '0;
                        r_cnt            <= '0;
                        r_out_can_accept <= 1'b0;
                        r_state          <= S_BUSY;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    r_work <= w_work_next;
                    if (w_last) begin
                        // Result registers load on the edge that enters DONE.
                        r_state          <= S_DONE;
                        r_out_valid      <= 1'b1;
                        r_out_can_accept <= 1'b1;
                        r_out_mask       <= w_work_next;
                        r_out_any        <= |w_work_next;
                        r_out_all        <= &(w_work_next | ~r_lane_mask);
                    end else begin
                        r_cnt <= r_cnt + c_LANE_W'(1);
                    end
                end
                default: begin
                    r_state          <= S_IDLE;
                    r_out_can_accept <= 1'b1;
                end
            endcase
        end
    end

    assign bus.out_can_accept_cmd = r_out_can_accept;
    assign bus.out_data_valid     = r_out_valid;
    assign bus.out_mask           = r_out_mask;
    assign bus.out_any            = r_out_any;
    assign bus.out_all            = r_out_all;

endmodule
`default_nettype wire

// File: tb/tb_snow64_bfloat16_vector_cmp_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module   : tb_snow64_bfloat16_vector_cmp_sequencer
// Brief    : Scoreboard bench for the BFloat16 vector compare sequencer.
// Revision : 1.0 - initial release
//==============================================================================
module tb_snow64_bfloat16_vector_cmp_sequencer;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    snow64_bfloat16_vector_cmp_sequencer_if #(.NUM_LANES(N)) bus();
    snow64_bfloat16_vector_cmp_sequencer #(.NUM_LANES(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [N-1:0] mask;
        logic         any;
        logic         all;
    } exp_t;

    exp_t sb_q[$];
    int   acc_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_valid  = 0;
    int   n_low    = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bus.out_data_valid)      n_valid <= n_valid + 1;
        if (!bus.out_can_accept_cmd) n_low   <= n_low + 1;
    end

    // Independent reference: map each value to an unsigned order key.
    function automatic logic [15:0] order_key(input logic [15:0] x);
        if (x[14:0] == 15'd0) return 16'h8000;
        return x[15] ? ~x : {1'b1, x[14:0]};
    endfunction

    function automatic exp_t model(input logic [1:0] op, input logic [16*N-1:0] a,
                                   input logic [16*N-1:0] b, input logic [N-1:0] m);
        exp_t e;
        logic [15:0] ka, kb;
        logic r;
        e.mask = '0;
        for (int i = 0; i < N; i++) begin
            ka = order_key(a[16*i +: 16]);
            kb = order_key(b[16*i +: 16]);
            case (op)
                2'd0:    r = (ka < kb);
                2'd1:    r = (kb < ka);
                2'd2:    r = !(kb < ka);
                default: r = !(ka < kb);
            endcase
            e.mask[i] = r & m[i];
        end
        e.any = 1'b0;
        e.all = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (e.mask[i]) e.any = 1'b1;
            if (m[i] && !e.mask[i]) e.all = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [16*N-1:0] fill(input logic [15:0] even_v, input logic [15:0] odd_v);
        logic [16*N-1:0] v;
        for (int i = 0; i < N; i++) v[16*i +: 16] = (i % 2 == 0) ? even_v : odd_v;
        return v;
    endfunction

    task automatic cycle_();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [1:0] op, input logic [16*N-1:0] a,
                             input logic [16*N-1:0] b, input logic [N-1:0] m);
        int guard = 0;
        while (!bus.out_can_accept_cmd && guard < 40) begin
            cycle_();
            guard++;
        end
        if (!bus.out_can_accept_cmd) begin
            n_checks++; n_fail++;
            $display("FAIL accept_wait: out_can_accept_cmd=%0b required 1", bus.out_can_accept_cmd);
        end
        bus.in_start = 1'b1; bus.in_op = op; bus.in_a = a; bus.in_b = b; bus.in_lane_mask = m;
        cycle_();
        bus.in_start = 1'b0;
    endtask

    task automatic send(input logic [1:0] op, input logic [16*N-1:0] a,
                        input logic [16*N-1:0] b, input logic [N-1:0] m, input exp_t e);
        drive_cmd(op, a, b, m);
        acc_q.push_back(cyc);
        sb_q.push_back(e);
    endtask

    task automatic check_result(input string name);
        int   guard = 0;
        int   acc;
        exp_t e;
        while (!bus.out_data_valid && guard < 40) begin
            cycle_();
            guard++;
        end
        n_checks++;
        if (!bus.out_data_valid) begin
            n_fail++;
            $display("FAIL %s_timeout: out_data_valid=0 after 40 cycles, required 1", name);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            if (acc_q.size() > 0) void'(acc_q.pop_front());
            return;
        end
        e   = sb_q.pop_front();
        acc = acc_q.pop_front();
        n_checks++;
        if (cyc - acc !== N) begin
            n_fail++;
            $display("FAIL %s_latency: valid %0d edges after accept, required %0d", name, cyc - acc, N);
        end
        n_checks++;
        if (bus.out_mask !== e.mask) begin
            n_fail++;
            $display("FAIL %s_mask: got %h required %h", name, bus.out_mask, e.mask);
        end
        n_checks++;
        if (bus.out_any !== e.any) begin
            n_fail++;
            $display("FAIL %s_any: got %b required %b", name, bus.out_any, e.any);
        end
        n_checks++;
        if (bus.out_all !== e.all) begin
            n_fail++;
            $display("FAIL %s_all: got %b required %b", name, bus.out_all, e.all);
        end
        cycle_();
        n_checks++;
        if (bus.out_data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_pulse: out_data_valid=%b one cycle later, required 0", name, bus.out_data_valid);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        n_checks++;
        if (bus.out_can_accept_cmd !== 1'b1 || bus.out_data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_ctrl: accept=%b valid=%b required accept=1 valid=0",
                     name, bus.out_can_accept_cmd, bus.out_data_valid);
        end
        n_checks++;
        if (bus.out_mask !== '0 || bus.out_any !== 1'b0 || bus.out_all !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_result: mask=%h any=%b all=%b required 0/0/0",
                     name, bus.out_mask, bus.out_any, bus.out_all);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_start = 1'b0; bus.in_op = '0; bus.in_a = '0; bus.in_b = '0; bus.in_lane_mask = '0;
        repeat (3) cycle_();
        rst = 1'b0;
        check_idle_outputs("reset");
    endtask

    task automatic test_slt_all_lanes();
        exp_t e;
        e.mask = 16'h5555; e.any = 1'b1; e.all = 1'b0;
        send(2'd0, fill(16'h3F80, 16'h4000), fill(16'h4000, 16'h4000), 16'hFFFF, e);
        check_result("slt_all");
    endtask

    task automatic test_reset_mid_command();
        int v0;
        drive_cmd(2'd1, fill(16'h4000, 16'h4000), fill(16'h3F80, 16'h3F80), 16'hFFFF);
        repeat (5) cycle_();
        v0  = n_valid;
        rst = 1'b1;
        repeat (3) cycle_();
        rst = 1'b0;
        check_idle_outputs("reset_mid");
        repeat (25) cycle_();
        n_checks++;
        if (n_valid !== v0) begin
            n_fail++;
            $display("FAIL reset_abort: %0d valid pulses after reset, required 0", n_valid - v0);
        end
    endtask

    task automatic test_signed_zero();
        logic [16*N-1:0] a, b;
        exp_t e;
        a = fill(16'h4000, 16'h4000);
        b = fill(16'h4000, 16'h4000);
        a[15:0] = 16'h8000; b[15:0] = 16'h0000;
        a[31:16] = 16'h0000; b[31:16] = 16'h8000;
        a[47:32] = 16'hBF80; b[47:32] = 16'h3F80;
        e.mask = 16'h0004; e.any = 1'b1; e.all = 1'b0;
        send(2'd0, a, b, 16'hFFFF, e);
        check_result("zero_slt");
        e.mask = 16'hFFFF; e.any = 1'b1; e.all = 1'b1;
        send(2'd2, a, b, 16'hFFFF, e);
        check_result("zero_sle");
    endtask

    task automatic test_sgt_sge();
        exp_t e;
        e.mask = 16'h00FF; e.any = 1'b1; e.all = 1'b1;
        send(2'd1, fill(16'h4000, 16'h4000), fill(16'h3F80, 16'h3F80), 16'h00FF, e);
        check_result("sgt");
        send(2'd3, fill(16'h4000, 16'h4000), fill(16'h4000, 16'h4000), 16'h00FF, e);
        check_result("sge_eq");
        e.mask = 16'h0000; e.any = 1'b0; e.all = 1'b1;
        send(2'd1, fill(16'h4000, 16'h4000), fill(16'h3F80, 16'h3F80), 16'h0000, e);
        check_result("mask_zero");
    endtask

    task automatic test_back_to_back();
        int   v0, acc;
        exp_t e1, e2;
        e1.mask = 16'h5555; e1.any = 1'b1; e1.all = 1'b0;
        e2.mask = 16'hF0F0; e2.any = 1'b1; e2.all = 1'b1;
        v0 = n_valid;
        bus.in_start = 1'b1; bus.in_op = 2'd0; bus.in_lane_mask = 16'hFFFF;
        bus.in_a = fill(16'h3F80, 16'h4000); bus.in_b = fill(16'h4000, 16'h4000);
        cycle_();
        acc = cyc;
        acc_q.push_back(acc);      sb_q.push_back(e1);
        acc_q.push_back(acc + N + 1); sb_q.push_back(e2);
        // Start stays high; these operands must not leak into the first result.
        bus.in_op = 2'd3; bus.in_lane_mask = 16'hF0F0;
        bus.in_a = fill(16'h4000, 16'h4000); bus.in_b = fill(16'h3F80, 16'h3F80);
        check_result("b2b_first");
        bus.in_start = 1'b0;
        bus.in_op = 2'd0;
        bus.in_a = {N{16'h0001}}; bus.in_b = {N{16'h7F00}}; bus.in_lane_mask = 16'hFFFF;
        check_result("b2b_second");
        repeat (20) cycle_();
        n_checks++;
        if (n_valid - v0 !== 2) begin
            n_fail++;
            $display("FAIL b2b_count: %0d valid pulses, required 2", n_valid - v0);
        end
    endtask

    task automatic test_busy_ignore();
        int   v0, l0;
        exp_t e;
        e.mask = 16'h00FF; e.any = 1'b1; e.all = 1'b1;
        v0 = n_valid;
        l0 = n_low;
        send(2'd1, fill(16'h4000, 16'h4000), fill(16'h3F80, 16'h3F80), 16'h00FF, e);
        repeat (5) cycle_();
        bus.in_start = 1'b1; bus.in_op = 2'd0; bus.in_lane_mask = 16'hFFFF;
        cycle_();
        bus.in_start = 1'b0;
        check_result("busy_ignore");
        repeat (25) cycle_();
        n_checks++;
        if (n_valid - v0 !== 1) begin
            n_fail++;
            $display("FAIL busy_count: %0d valid pulses, required 1", n_valid - v0);
        end
        n_checks++;
        if (n_low - l0 !== N) begin
            n_fail++;
            $display("FAIL accept_low: accept low %0d cycles, required %0d", n_low - l0, N);
        end
    endtask

    task automatic test_random();
        logic [16*N-1:0] a, b;
        logic [N-1:0]    m;
        logic [1:0]      op;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++) begin
                a[16*i +: 16] = 16'($urandom);
                b[16*i +: 16] = ($urandom_range(0, 3) == 0) ? a[16*i +: 16] : 16'($urandom);
                if ($urandom_range(0, 7) == 0) b[16*i +: 16] = {~a[16*i+15], 15'd0};
            end
            m  = 16'($urandom);
            op = 2'($urandom_range(0, 3));
            send(op, a, b, m, model(op, a, b, m));
            check_result($sformatf("rand%0d", k));
        end
    endtask

    initial begin
        test_reset();
        test_slt_all_lanes();
        test_reset_mid_command();
        test_signed_zero();
        test_sgt_sge();
        test_back_to_back();
        test_busy_ignore();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
